// File: rtl/apb_rr_arbiter_pkg.sv
// Shared types and constants for the two-requester APB round-robin arbiter.
package apb_rr_arbiter_pkg;

   localparam int DEF_ADDR_W = 5;
   localparam int DEF_DATA_W = 8;

   // Arbiter transfer phases.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } arb_state_e;

   // One-hot ownership codes driven on the grant output.
   localparam logic [1:0] GRANT_NONE = 2'b00;
   localparam logic [1:0] GRANT_S0   = 2'b01;
   localparam logic [1:0] GRANT_S1   = 2'b10;

   // New last-grant pointer value after granting g: 1 when s1 won, else 0.
   function automatic logic next_ptr(input logic [1:0] g);
      logic p;
      p = 1'b0;
      if (g == GRANT_S1) begin
         p = 1'b1;
      end else begin
         p = 1'b0;
      end
      return p;
   endfunction

endpackage

// File: rtl/apb_rr_arbiter_if.sv
// Bundle of both requester APB ports, the completer APB port and the grant
// indication. The arbiter uses the slave view; the surrounding system (or a
// bench) uses the master view.
interface apb_rr_arbiter_if
   import apb_rr_arbiter_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) ();

   logic              s0_psel;
   logic              s0_penable;
   logic              s0_pwrite;
   logic [ADDR_W-1:0] s0_paddr;
   logic [DATA_W-1:0] s0_pwdata;
   logic [DATA_W-1:0] s0_prdata;
   logic              s0_pready;
   logic              s0_pslverr;

   logic              s1_psel;
   logic              s1_penable;
   logic              s1_pwrite;
   logic [ADDR_W-1:0] s1_paddr;
   logic [DATA_W-1:0] s1_pwdata;
   logic [DATA_W-1:0] s1_prdata;
   logic              s1_pready;
   logic              s1_pslverr;

   logic              m_psel;
   logic              m_penable;
   logic              m_pwrite;
   logic [ADDR_W-1:0] m_paddr;
   logic [DATA_W-1:0] m_pwdata;
   logic [DATA_W-1:0] m_prdata;
   logic              m_pready;

   logic [1:0]        grant;

   // Arbiter-side view.
   modport slave (
      input  s0_psel, s0_penable, s0_pwrite, s0_paddr, s0_pwdata,
      output s0_prdata, s0_pready, s0_pslverr,
      input  s1_psel, s1_penable, s1_pwrite, s1_paddr, s1_pwdata,
      output s1_prdata, s1_pready, s1_pslverr,
      output m_psel, m_penable, m_pwrite, m_paddr, m_pwdata,
      input  m_prdata, m_pready,
      output grant
   );

   // Environment-side view: requesters and completer together.
   modport master (
      output s0_psel, s0_penable, s0_pwrite, s0_paddr, s0_pwdata,
      input  s0_prdata, s0_pready, s0_pslverr,
      output s1_psel, s1_penable, s1_pwrite, s1_paddr, s1_pwdata,
      input  s1_prdata, s1_pready, s1_pslverr,
      input  m_psel, m_penable, m_pwrite, m_paddr, m_pwdata,
      output m_prdata, m_pready,
      input  grant
   );

endinterface

// File: rtl/apb_rr_arbiter_pick.sv
// Combinational 2-way round-robin picker. The last-grant pointer is held by
// the parent; last=1 means s1 won most recently, so s0 wins a tie.
module rr_pick2
   import apb_rr_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] gnt
);

   // Select one requester, alternating on ties.
   always_comb begin
      gnt = GRANT_NONE;
      case (req)
         2'b00:   gnt = GRANT_NONE;
         2'b01:   gnt = GRANT_S0;
         2'b10:   gnt = GRANT_S1;
         2'b11: begin
            if (last) begin
               gnt = GRANT_S0;
            end else begin
               gnt = GRANT_S1;
            end
         end
         default: gnt = GRANT_NONE;
      endcase
   end

endmodule

// File: rtl/apb_rr_arbiter.sv
// Two-requester APB arbiter: round-robin selection, one registered transfer
// at a time to the completer, response routed back to the winner, and an
// optional abort of completer transfers that never assert m_pready.
module apb_rr_arbiter
   import apb_rr_arbiter_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int TIMEOUT = 16
) (
   input  logic            clk,
   input  logic            rst,
   apb_rr_arbiter_if.slave bus
);

   localparam logic [1:0] IDLE   = ST_IDLE;
   localparam logic [1:0] SETUP  = ST_SETUP;
   localparam logic [1:0] ACCESS = ST_ACCESS;
   localparam logic [1:0] RESP   = ST_RESP;

   // Counter sized to hold TIMEOUT; a single bit is kept when the abort is off.
   localparam int CNT_W = (TIMEOUT > 32'sd0) ? $clog2(TIMEOUT + 32'sd1) : 32'sd1;
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 32'sd0) ? CNT_W'(TIMEOUT - 32'sd1)
                                                              : {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

   logic [1:0]        state_r;
   logic              last_r;
   logic [1:0]        grant_r;
   logic [CNT_W-1:0]  tmo_cnt_r;

   logic              m_psel_r;
   logic              m_penable_r;
   logic              m_pwrite_r;
   logic [ADDR_W-1:0] m_paddr_r;
   logic [DATA_W-1:0] m_pwdata_r;

   logic [DATA_W-1:0] s0_prdata_r;
   logic              s0_pready_r;
   logic              s0_pslverr_r;
   logic [DATA_W-1:0] s1_prdata_r;
   logic              s1_pready_r;
   logic              s1_pslverr_r;

   logic [1:0]        req_s;
   logic [1:0]        pick_s;
   logic              win_write_s;
   logic [ADDR_W-1:0] win_addr_s;
   logic [DATA_W-1:0] win_wdata_s;
   logic              done_s;
   logic              tmo_hit_s;
   logic              unused_ok_s;

   // A request is psel alone; penable from the requesters carries no extra
   // information for arbitration and is deliberately ignored.
   assign unused_ok_s = &{1'b0, bus.s0_penable, bus.s1_penable};

   assign req_s = {bus.s1_psel, bus.s0_psel};

   rr_pick2 u_pick (
      .req  (req_s),
      .last (last_r),
      .gnt  (pick_s)
   );

   // Route the command fields of whichever requester the picker chose.
   always_comb begin
      win_write_s = 1'b0;
      win_addr_s  = {ADDR_W{1'b0}};
      win_wdata_s = {DATA_W{1'b0}};
      if (pick_s == GRANT_S1) begin
         win_write_s = bus.s1_pwrite;
         win_addr_s  = bus.s1_paddr;
         win_wdata_s = bus.s1_pwdata;
      end else begin
         win_write_s = bus.s0_pwrite;
         win_addr_s  = bus.s0_paddr;
         win_wdata_s = bus.s0_pwdata;
      end
   end

   // Completion conditions evaluated during ACCESS.
   always_comb begin
      done_s    = 1'b0;
      tmo_hit_s = 1'b0;
      if (state_r == ACCESS) begin
         done_s    = bus.m_pready;
         tmo_hit_s = (TIMEOUT != 32'sd0) && !bus.m_pready && (tmo_cnt_r == CNT_LAST);
      end else begin
         done_s    = 1'b0;
         tmo_hit_s = 1'b0;
      end
   end

   // Phase sequencing, ownership and round-robin pointer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
         last_r  <= 1'b1;
         grant_r <= GRANT_NONE;
      end else begin
         case (state_r)
            IDLE: begin
               if (pick_s != GRANT_NONE) begin
                  state_r <= SETUP;
                  grant_r <= pick_s;
                  last_r  <= next_ptr(pick_s);
               end
            end
            SETUP:  state_r <= ACCESS;
            ACCESS: begin
               if (done_s || tmo_hit_s) begin
                  state_r <= RESP;
               end
            end
            RESP: begin
               state_r <= IDLE;
               grant_r <= GRANT_NONE;
            end
            default: begin
               state_r <= IDLE;
               grant_r <= GRANT_NONE;
            end
         endcase
      end
   end

   // Completer-side command registers: held stable through SETUP and ACCESS,
   // zero at all other times.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_psel_r    <= 1'b0;
         m_penable_r <= 1'b0;
         m_pwrite_r  <= 1'b0;
         m_paddr_r   <= {ADDR_W{1'b0}};
         m_pwdata_r  <= {DATA_W{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (pick_s != GRANT_NONE) begin
                  m_psel_r    <= 1'b1;
                  m_penable_r <= 1'b0;
                  m_pwrite_r  <= win_write_s;
                  m_paddr_r   <= win_addr_s;
                  m_pwdata_r  <= win_wdata_s;
               end
            end
            SETUP: m_penable_r <= 1'b1;
            ACCESS: begin
               if (done_s || tmo_hit_s) begin
                  m_psel_r    <= 1'b0;
                  m_penable_r <= 1'b0;
                  m_pwrite_r  <= 1'b0;
                  m_paddr_r   <= {ADDR_W{1'b0}};
                  m_pwdata_r  <= {DATA_W{1'b0}};
               end
            end
            default: begin
               m_psel_r    <= 1'b0;
               m_penable_r <= 1'b0;
               m_pwrite_r  <= 1'b0;
               m_paddr_r   <= {ADDR_W{1'b0}};
               m_pwdata_r  <= {DATA_W{1'b0}};
            end
         endcase
      end
   end

   // ACCESS wait-cycle counter; cleared in SETUP, saturates instead of wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_cnt_r <= {CNT_W{1'b0}};
      end else begin
         case (state_r)
            SETUP: tmo_cnt_r <= {CNT_W{1'b0}};
            ACCESS: begin
               if (!done_s && !tmo_hit_s && (tmo_cnt_r != CNT_MAX)) begin
                  tmo_cnt_r <= tmo_cnt_r + CNT_ONE;
               end
            end
            default: tmo_cnt_r <= tmo_cnt_r;
         endcase
      end
   end

   // Requester responses: a one-cycle pready (with pslverr) in RESP for the
   // owner only; read data is held until the owner's next completion.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s0_prdata_r  <= {DATA_W{1'b0}};
         s0_pready_r  <= 1'b0;
         s0_pslverr_r <= 1'b0;
         s1_prdata_r  <= {DATA_W{1'b0}};
         s1_pready_r  <= 1'b0;
         s1_pslverr_r <= 1'b0;
      end else begin
         case (state_r)
            ACCESS: begin
               if (done_s) begin
                  if (grant_r == GRANT_S0) begin
                     s0_prdata_r  <= bus.m_prdata;
                     s0_pready_r  <= 1'b1;
                     s0_pslverr_r <= 1'b0;
                  end
                  if (grant_r == GRANT_S1) begin
                     s1_prdata_r  <= bus.m_prdata;
                     s1_pready_r  <= 1'b1;
                     s1_pslverr_r <= 1'b0;
                  end
               end else if (tmo_hit_s) begin
                  if (grant_r == GRANT_S0) begin
                     s0_prdata_r  <= {DATA_W{1'b0}};
                     s0_pready_r  <= 1'b1;
                     s0_pslverr_r <= 1'b1;
                  end
                  if (grant_r == GRANT_S1) begin
                     s1_prdata_r  <= {DATA_W{1'b0}};
                     s1_pready_r  <= 1'b1;
                     s1_pslverr_r <= 1'b1;
                  end
               end
            end
            default: begin
               s0_pready_r  <= 1'b0;
               s0_pslverr_r <= 1'b0;
               s1_pready_r  <= 1'b0;
               s1_pslverr_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.m_psel     = m_psel_r;
   assign bus.m_penable  = m_penable_r;
   assign bus.m_pwrite   = m_pwrite_r;
   assign bus.m_paddr    = m_paddr_r;
   assign bus.m_pwdata   = m_pwdata_r;
   assign bus.s0_prdata  = s0_prdata_r;
   assign bus.s0_pready  = s0_pready_r;
   assign bus.s0_pslverr = s0_pslverr_r;
   assign bus.s1_prdata  = s1_prdata_r;
   assign bus.s1_pready  = s1_pready_r;
   assign bus.s1_pslverr = s1_pslverr_r;
   assign bus.grant      = grant_r;

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Directed bench for apb_rr_arbiter with hand-computed cycle expectations.
// Cycle 0 is the IDLE cycle in which a request is first presented.
module tb_apb_rr_arbiter;
   import apb_rr_arbiter_pkg::*;

   localparam int ADDR_W  = 5;
   localparam int DATA_W  = 8;
   localparam int TIMEOUT = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests_run    = 0;
   int   tests_failed = 0;

   apb_rr_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   apb_rr_arbiter #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic req0(input logic sel, input logic wr, input logic [4:0] a, input logic [7:0] d);
      bus.s0_psel   = sel;
      bus.s0_pwrite = wr;
      bus.s0_paddr  = a;
      bus.s0_pwdata = d;
   endtask

   task automatic req1(input logic sel, input logic wr, input logic [4:0] a, input logic [7:0] d);
      bus.s1_psel   = sel;
      bus.s1_pwrite = wr;
      bus.s1_paddr  = a;
      bus.s1_pwdata = d;
   endtask

   initial begin
      logic [1:0] exp_g;
      bus.s0_penable = 1'b0;
      bus.s1_penable = 1'b0;
      req0(1'b0, 1'b0, 5'h00, 8'h00);
      req1(1'b0, 1'b0, 5'h00, 8'h00);
      bus.m_prdata = 8'h00;
      bus.m_pready = 1'b0;

      // Reset state
      tick();
      tick();
      check_val("rst_grant", 32'(bus.grant), 32'h0);
      check_val("rst_m_psel", 32'(bus.m_psel), 32'h0);
      check_val("rst_m_penable", 32'(bus.m_penable), 32'h0);
      check_val("rst_s0_pready", 32'(bus.s0_pready), 32'h0);
      check_val("rst_s1_pready", 32'(bus.s1_pready), 32'h0);
      rst = 1'b0;

      // 1: s0 write 0x05/0xA5, zero wait states
      bus.m_pready = 1'b1;
      req0(1'b1, 1'b1, 5'h05, 8'hA5);
      check_val("t1_c0_grant", 32'(bus.grant), 32'h0);
      tick();
      check_val("t1_c1_psel", 32'(bus.m_psel), 32'h1);
      check_val("t1_c1_penable", 32'(bus.m_penable), 32'h0);
      check_val("t1_c1_grant", 32'(bus.grant), 32'h1);
      check_val("t1_c1_paddr", 32'(bus.m_paddr), 32'h05);
      check_val("t1_c1_pwdata", 32'(bus.m_pwdata), 32'hA5);
      check_val("t1_c1_pwrite", 32'(bus.m_pwrite), 32'h1);
      bus.s0_penable = 1'b1;
      tick();
      check_val("t1_c2_penable", 32'(bus.m_penable), 32'h1);
      check_val("t1_c2_grant", 32'(bus.grant), 32'h1);
      check_val("t1_c2_pready", 32'(bus.s0_pready), 32'h0);
      tick();
      check_val("t1_c3_pready", 32'(bus.s0_pready), 32'h1);
      check_val("t1_c3_pslverr", 32'(bus.s0_pslverr), 32'h0);
      check_val("t1_c3_psel", 32'(bus.m_psel), 32'h0);
      bus.s0_penable = 1'b0;
      req0(1'b0, 1'b0, 5'h00, 8'h00);
      tick();
      check_val("t1_c4_pready", 32'(bus.s0_pready), 32'h0);
      check_val("t1_c4_grant", 32'(bus.grant), 32'h0);
      check_val("t1_c4_paddr", 32'(bus.m_paddr), 32'h00);

      // 2: s1 read 0x1F, two wait states, data 0x3C
      bus.m_pready = 1'b0;
      bus.m_prdata = 8'h3C;
      req1(1'b1, 1'b0, 5'h1F, 8'h00);
      tick();
      check_val("t2_c1_grant", 32'(bus.grant), 32'h2);
      check_val("t2_c1_paddr", 32'(bus.m_paddr), 32'h1F);
      check_val("t2_c1_pwrite", 32'(bus.m_pwrite), 32'h0);
      tick();
      tick();
      check_val("t2_c3_pready", 32'(bus.s1_pready), 32'h0);
      check_val("t2_c3_psel", 32'(bus.m_psel), 32'h1);
      tick();
      bus.m_pready = 1'b1;
      tick();
      check_val("t2_c5_pready", 32'(bus.s1_pready), 32'h1);
      check_val("t2_c5_prdata", 32'(bus.s1_prdata), 32'h3C);
      check_val("t2_c5_s0_pready", 32'(bus.s0_pready), 32'h0);
      req1(1'b0, 1'b0, 5'h00, 8'h00);
      tick();
      check_val("t2_c6_pready", 32'(bus.s1_pready), 32'h0);

      // 3: simultaneous requests after reset, s0 first
      rst = 1'b1;
      tick();
      rst = 1'b0;
      req0(1'b1, 1'b1, 5'h01, 8'h11);
      req1(1'b1, 1'b1, 5'h02, 8'h22);
      tick();
      check_val("t3_c1_grant", 32'(bus.grant), 32'h1);
      check_val("t3_c1_paddr", 32'(bus.m_paddr), 32'h01);
      tick();
      tick();
      check_val("t3_c3_s0_pready", 32'(bus.s0_pready), 32'h1);
      check_val("t3_c3_s1_pready", 32'(bus.s1_pready), 32'h0);
      req0(1'b0, 1'b0, 5'h00, 8'h00);
      tick();
      check_val("t3_c4_grant", 32'(bus.grant), 32'h0);
      tick();
      check_val("t3_c5_grant", 32'(bus.grant), 32'h2);
      check_val("t3_c5_paddr", 32'(bus.m_paddr), 32'h02);
      check_val("t3_c5_pwdata", 32'(bus.m_pwdata), 32'h22);
      tick();
      tick();
      check_val("t3_c7_s1_pready", 32'(bus.s1_pready), 32'h1);
      req1(1'b0, 1'b0, 5'h00, 8'h00);
      tick();

      // 4: both requesting continuously, six alternating transfers
      req0(1'b1, 1'b1, 5'h03, 8'h33);
      req1(1'b1, 1'b1, 5'h04, 8'h44);
      for (int k = 0; k < 6; k++) begin
         exp_g = ((k % 2) == 0) ? 2'b01 : 2'b10;
         tick();
         check_val($sformatf("t4_grant_%0d", k), 32'(bus.grant), 32'(exp_g));
         tick();
         tick();
         check_val($sformatf("t4_pready_%0d", k), 32'({bus.s1_pready, bus.s0_pready}), 32'(exp_g));
         tick();
         check_val($sformatf("t4_idle_%0d", k), 32'(bus.grant), 32'h0);
      end
      req0(1'b0, 1'b0, 5'h00, 8'h00);
      req1(1'b0, 1'b0, 5'h00, 8'h00);

      // 5: completer never ready -> abort after 16 ACCESS cycles
      bus.m_pready = 1'b0;
      bus.m_prdata = 8'hFF;
      req0(1'b1, 1'b0, 5'h0A, 8'h00);
      tick();
      check_val("t5_c1_grant", 32'(bus.grant), 32'h1);
      repeat (16) tick();
      check_val("t5_c17_psel", 32'(bus.m_psel), 32'h1);
      check_val("t5_c17_pready", 32'(bus.s0_pready), 32'h0);
      tick();
      check_val("t5_c18_psel", 32'(bus.m_psel), 32'h0);
      check_val("t5_c18_pready", 32'(bus.s0_pready), 32'h1);
      check_val("t5_c18_pslverr", 32'(bus.s0_pslverr), 32'h1);
      check_val("t5_c18_prdata", 32'(bus.s0_prdata), 32'h00);
      req0(1'b0, 1'b0, 5'h00, 8'h00);
      tick();
      check_val("t5_c19_pslverr", 32'(bus.s0_pslverr), 32'h0);
      bus.m_pready = 1'b1;
      bus.m_prdata = 8'h5A;
      req0(1'b1, 1'b0, 5'h0B, 8'h00);
      repeat (3) tick();
      check_val("t5_next_pready", 32'(bus.s0_pready), 32'h1);
      check_val("t5_next_pslverr", 32'(bus.s0_pslverr), 32'h0);
      check_val("t5_next_prdata", 32'(bus.s0_prdata), 32'h5A);
      req0(1'b0, 1'b0, 5'h00, 8'h00);
      tick();

      // 6: reset during ACCESS, then a lone s1 request
      bus.m_pready = 1'b0;
      req0(1'b1, 1'b1, 5'h03, 8'h99);
      tick();
      tick();
      check_val("t6_access_psel", 32'(bus.m_psel), 32'h1);
      #2;
      rst = 1'b1;
      #1;
      check_val("t6_rst_psel", 32'(bus.m_psel), 32'h0);
      check_val("t6_rst_penable", 32'(bus.m_penable), 32'h0);
      check_val("t6_rst_grant", 32'(bus.grant), 32'h0);
      check_val("t6_rst_paddr", 32'(bus.m_paddr), 32'h00);
      req0(1'b0, 1'b0, 5'h00, 8'h00);
      req1(1'b1, 1'b0, 5'h04, 8'h00);
      bus.m_pready = 1'b1;
      bus.m_prdata = 8'h77;
      #1;
      rst = 1'b0;
      tick();
      check_val("t6_c1_grant", 32'(bus.grant), 32'h2);
      check_val("t6_c1_paddr", 32'(bus.m_paddr), 32'h04);
      tick();
      tick();
      check_val("t6_c3_s1_pready", 32'(bus.s1_pready), 32'h1);
      check_val("t6_c3_s1_prdata", 32'(bus.s1_prdata), 32'h77);
      check_val("t6_c3_s0_pready", 32'(bus.s0_pready), 32'h0);
      req1(1'b0, 1'b0, 5'h00, 8'h00);
      tick();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/apb_rr_arbiter.md
Name: apb_rr_arbiter

Overview:
Two-requester APB arbiter that shares the single 5-bit-address, 8-bit-data APB register bus between the I2C-to-APB adapter (port s0) and a second bus master (port s1, e.g. a debug or SPI bridge). It uses round-robin arbitration, forwards one transfer at a time through registered outputs, and returns read data and completion to the granted requester. It also aborts hung completer transfers after a programmable timeout, returning an error to the requester.

Parameters:
ADDR_W, 5, APB address width
DATA_W, 8, APB data width
TIMEOUT, 16, max ACCESS cycles awaiting m_pready before abort; 0 disables timeout

Ports:
clk  input  1  clock; also the APB clock for all ports
rst  input  1  asynchronous reset, active-high
s0_psel, s0_penable, s0_pwrite  input  1 each  requester 0 APB controls
s0_paddr  input  ADDR_W  requester 0 address
s0_pwdata  input  DATA_W  requester 0 write data
s0_prdata  output  DATA_W  requester 0 read data
s0_pready, s0_pslverr  output  1 each  requester 0 completion / error
s1_*  (same set as s0_*)  requester 1
m_psel, m_penable, m_pwrite  output  1 each  completer-side APB controls
m_paddr  output  ADDR_W  completer-side address
m_pwdata  output  DATA_W  completer-side write data
m_prdata  input  DATA_W  completer read data
m_pready  input  1  completer ready
grant  output  2  one-hot owner of current transfer (00 when IDLE)

Behaviour:
- Reset (async assert, sync release): state=IDLE; all outputs 0; last-grant pointer = 1, so s0 wins the first tie.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - Request_i = s_i_psel. Neither high -> stay.
  - One high -> grant it. Both high -> grant the one not in the last-grant pointer.
  - On grant: register paddr/pwrite/pwdata of the winner into m_*; m_psel=1, m_penable=0; set grant; update pointer; -> SETUP.
- SETUP: m_penable=1; clear timeout counter; -> ACCESS.
- ACCESS:
  - m_pready=1 -> capture m_prdata into winner's s_prdata; drop m_psel/m_penable; -> RESP.
  - Else if TIMEOUT!=0 and counter==TIMEOUT-1 -> drop m_psel/m_penable; winner's s_prdata=0; set s_pslverr; -> RESP.
  - Otherwise counter increments.
- RESP:
  - Winner's s_pready=1 for exactly one cycle; s_pslverr valid only this cycle.
  - Clear grant; -> IDLE.
- Minimum upstream latency: s_psel seen in IDLE at cycle 0, s_pready at cycle 3 (completer with zero wait states). Each wait state adds one cycle.
- Non-granted requester: s_pready held 0; its s_psel stays pending and is served next. Its address/data are sampled only when it is granted.
- Back-to-back: s_psel still high in the IDLE cycle after RESP is a new request and is arbitrated again. With both requesting continuously, grants alternate s0,s1,s0,...
- m_pwrite/m_paddr/m_pwdata are stable from SETUP through ACCESS. m_* are zero outside SETUP/ACCESS.
- Granted requester dropping s_psel mid-transfer (protocol violation): the downstream transfer still completes; the RESP pulse is still issued.
- Reset mid-transfer: immediate return to IDLE; m_psel drops asynchronously; the transfer is lost without response.
- Timeout counter width: $clog2(TIMEOUT+1); saturates and never wraps.

Decomposition:
- Package apb_rr_arbiter_pkg:
  - state enum (IDLE, SETUP, ACCESS, RESP)
  - GRANT_NONE/GRANT_S0/GRANT_S1 one-hot constants
  - default ADDR_W/DATA_W
- Sub-module rr_pick2: combinational 2-way round-robin picker (req[1:0], last -> gnt one-hot). Its pointer register lives in the parent.

Test Plan:
- s0 write addr 0x05 data 0xA5, m_pready tied 1 -> m_psel cycle1, m_penable cycle2, s0_pready pulse cycle3, s0_pslverr=0; completer sees 0x05/0xA5; grant=01 cycles1-2.
- s1 read addr 0x1F, completer returns 0x3C after 2 wait states -> s1_prdata=0x3C with s1_pready at cycle5; s0_pready stays 0.
- s0 and s1 assert psel in the same cycle after reset -> s0 served first, then s1 starting in the IDLE cycle after s0's RESP; grant sequence 01,00,10.
- Both requesting continuously for 6 transfers -> grants strictly alternate s0,s1,s0,s1,s0,s1; no starvation.
- TIMEOUT=16, m_pready held 0 -> after 16 ACCESS cycles m_psel drops; the requester gets pready=1, pslverr=1, prdata=0x00; the next request is served normally.
- Assert rst during ACCESS -> all outputs 0 immediately; after release, a pending s1 request is granted before s0 (pointer reset to 1 -> tie favours s0; s1 alone -> s1).
